sdram_sched: RTL and testbench

- Scheduler between three SDRAM requesters (ch0 = CPU/PRG, ch1 = PPU/CHR, ch2 = API/QSPI loader) and the single SDRAM command engine.
- Serialises accesses and routes read data back to the granted requester.
- Inserts auto-refresh, either opportunistically on the mapper's refresh hint or forced when the refresh deadline expires.
- Bounds API starvation so loader traffic always progresses while the console runs.

---
 rtl/sdram_sched.sv | 164 ++++++++++++++++
 tb/tb_sdram_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_sched.sv
// Arbiter between the CPU, PPU and API requesters and the single SDRAM command engine.
// It also inserts auto-refresh and bounds how long the API channel can be starved.
module sdram_sched #(
    parameter int ADDR_BITS        = 22,
    parameter int REFRESH_INTERVAL = 780,
    parameter int API_MAX_WAIT     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           req,
    input  logic [2:0]           we,
    input  logic [ADDR_BITS-1:0] addr0,
    input  logic [ADDR_BITS-1:0] addr1,
    input  logic [ADDR_BITS-1:0] addr2,
    input  logic [15:0]          wdata0,
    input  logic [15:0]          wdata1,
    input  logic [15:0]          wdata2,
    input  logic [1:0]           wmask0,
    input  logic [1:0]           wmask1,
    input  logic [1:0]           wmask2,
    output logic [2:0]           ack,
    output logic [15:0]          rdata,
    input  logic                 refresh_hint,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 cmd_refresh,
    output logic                 cmd_we,
    output logic [ADDR_BITS-1:0] cmd_addr,
    output logic [15:0]          cmd_wdata,
    output logic [1:0]           cmd_mask,
    input  logic                 done,
    input  logic [15:0]          done_rdata
);

    localparam int RC_W = $clog2(REFRESH_INTERVAL + 1);
    localparam int SC_W = $clog2(API_MAX_WAIT + 1);
    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(REFRESH_INTERVAL);
    localparam logic [RC_W-1:0] RC_HALF = RC_W'(REFRESH_INTERVAL / 2);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(API_MAX_WAIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // One-hot grant: {refresh, ch2, ch1, ch0}
    localparam logic [3:0] G_CH0 = 4'b0001;
    localparam logic [3:0] G_CH1 = 4'b0010;
    localparam logic [3:0] G_CH2 = 4'b0100;
    localparam logic [3:0] G_REF = 4'b1000;

    logic [1:0]           state_q, state_d;
    logic [3:0]           gnt_q, gnt_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [15:0]          wdata_q, wdata_d;
    logic [1:0]           mask_q, mask_d;
    logic [2:0]           ack_q, ack_d;
    logic [15:0]          rdata_q, rdata_d;
    logic [RC_W-1:0]      ref_cnt_q, ref_cnt_d;
    logic [SC_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic [3:0]           win;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        ack_d        = 3'b000;
        rdata_d      = 16'h0000;
        ref_cnt_d    = (ref_cnt_q >= RC_MAX) ? RC_MAX : ref_cnt_q + 1'b1;
        starve_cnt_d = req[2] ? starve_cnt_q : '0;
        win          = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (ref_cnt_q >= RC_MAX)                            win = G_REF;
                else if (req[2] && starve_cnt_q >= SC_MAX)          win = G_CH2;
                else if (req[1])                                    win = G_CH1;
                else if (req[0])                                    win = G_CH0;
                else if (req[2])                                    win = G_CH2;
                else if (refresh_hint && ref_cnt_q >= RC_HALF)      win = G_REF;

                // Fields are captured here so requesters may change inputs while in flight
                case (win)
                    G_CH0: begin
                        we_d = we[0]; addr_d = addr0; wdata_d = wdata0; mask_d = wmask0;
                    end
                    G_CH1: begin
                        we_d = we[1]; addr_d = addr1; wdata_d = wdata1; mask_d = wmask1;
                    end
                    G_CH2: begin
                        we_d = we[2]; addr_d = addr2; wdata_d = wdata2; mask_d = wmask2;
                    end
                    G_REF: begin
                        we_d = 1'b0; addr_d = '0; wdata_d = 16'h0000; mask_d = 2'b00;
                    end
                    default: ;
                endcase

                if (win != 4'b0000) begin
                    gnt_d   = win;
                    state_d = S_ISSUE;
                end

                if ((win == G_CH0 || win == G_CH1) && req[2] && starve_cnt_q < SC_MAX)
                    starve_cnt_d = starve_cnt_q + 1'b1;
                else if (win == G_CH2)
                    starve_cnt_d = '0;
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d = S_WAIT;
                    if (gnt_q[3]) ref_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (done) begin
                    state_d = S_IDLE;
                    ack_d   = gnt_q[2:0];
                    if (gnt_q[2:0] != 3'b000 && !we_q) rdata_d = done_rdata;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gnt_q        <= 4'b0000;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 16'h0000;
            mask_q       <= 2'b00;
            ack_q        <= 3'b000;
            rdata_q      <= 16'h0000;
            ref_cnt_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            ref_cnt_q    <= ref_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign cmd_valid   = (state_q == S_ISSUE);
    assign cmd_refresh = gnt_q[3];
    assign cmd_we      = we_q;
    assign cmd_addr    = addr_q;
    assign cmd_wdata   = wdata_q;
    assign cmd_mask    = mask_q;
    assign ack         = ack_q;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_sdram_sched.sv
// Directed bench for sdram_sched with a small engine model that accepts and completes commands.
module tb_sdram_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [2:0]  we = 3'b000;
    logic [21:0] addr0 = '0, addr1 = '0, addr2 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
    logic [1:0]  wmask0 = '0, wmask1 = '0, wmask2 = '0;
    logic [2:0]  ack;
    logic [15:0] rdata;
    logic        refresh_hint = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_refresh;
    logic        cmd_we;
    logic [21:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  cmd_mask;
    logic        done;
    logic [15:0] done_rdata;

    int checks = 0;
    int failures = 0;

    // Engine model controls
    logic        eng_en = 1'b1;
    int          ready_dly = 0;
    int          done_dly = 4;

    // Monitor counters
    int ack_cnt0, ack_cnt1, ack_cnt2, multi_ack, ref_acc;

    always #5 clk = ~clk;

    sdram_sched dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .wmask0(wmask0), .wmask1(wmask1), .wmask2(wmask2),
        .ack(ack), .rdata(rdata), .refresh_hint(refresh_hint),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_refresh(cmd_refresh),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .done(done), .done_rdata(done_rdata)
    );

    // Engine: accept after ready_dly cycles of cmd_valid, done pulse done_dly cycles after accept.
    // Read data returned is the accepted address low half XOR 16'h5A5A.
    initial begin
        logic        busy;
        int          rcnt, dcnt;
        logic [21:0] lat_addr;
        busy = 1'b0; rcnt = 0; dcnt = 0; lat_addr = '0;
        cmd_ready = 1'b0; done = 1'b0; done_rdata = 16'h0;
        forever begin
            @(posedge clk); #1;
            done = 1'b0; done_rdata = 16'h0;
            if (reset || !eng_en) begin
                cmd_ready = 1'b0; busy = 1'b0; rcnt = 0;
            end else if (busy) begin
                if (dcnt <= 1) begin
                    done = 1'b1; done_rdata = lat_addr[15:0] ^ 16'h5A5A; busy = 1'b0;
                end else dcnt--;
            end else if (cmd_ready) begin
                cmd_ready = 1'b0; busy = 1'b1; dcnt = done_dly; rcnt = 0;
            end else if (cmd_valid) begin
                if (rcnt >= ready_dly) begin
                    cmd_ready = 1'b1; lat_addr = cmd_addr;
                end else rcnt++;
            end
        end
    end

    initial begin
        ack_cnt0 = 0; ack_cnt1 = 0; ack_cnt2 = 0; multi_ack = 0; ref_acc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ack_cnt0 = 0; ack_cnt1 = 0; ack_cnt2 = 0; multi_ack = 0; ref_acc = 0;
            end else begin
                ack_cnt0 += int'(ack[0]);
                ack_cnt1 += int'(ack[1]);
                ack_cnt2 += int'(ack[2]);
                if ($countones(ack) > 1) multi_ack++;
                if (cmd_valid && cmd_ready && cmd_refresh) ref_acc++;
            end
        end
    end

    task automatic do_reset();
        req = 3'b000; we = 3'b000; refresh_hint = 1'b0;
        eng_en = 1'b1; ready_dly = 0; done_dly = 4;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ack(input int maxc, output logic [2:0] a);
        a = 3'b000;
        for (int i = 0; i < maxc && a == 3'b000; i++) begin
            @(negedge clk);
            a = ack;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b want=0", cmd_valid); end
        checks++; if (ack !== 3'b000) begin failures++; $display("FAIL reset_ack got=%b want=000", ack); end
        checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0000", rdata); end
        checks++; if (cmd_refresh !== 1'b0) begin failures++; $display("FAIL reset_cmd_refresh got=%b want=0", cmd_refresh); end
        checks++; if (dut.ref_cnt_q !== 10'd0) begin failures++; $display("FAIL reset_ref_cnt got=%0d want=0", dut.ref_cnt_q); end
        checks++; if (dut.starve_cnt_q !== 4'd0) begin failures++; $display("FAIL reset_starve_cnt got=%0d want=0", dut.starve_cnt_q); end
    endtask

    task automatic test_priority();
        logic [2:0] a;
        do_reset();
        addr0 = 22'h000AA; addr1 = 22'h00111; we = 3'b000;
        req = 3'b011;
        wait_ack(40, a);
        checks++; if (a !== 3'b010) begin failures++; $display("FAIL prio_first_ack got=%b want=010", a); end
        checks++; if (rdata !== (16'h0111 ^ 16'h5A5A)) begin failures++; $display("FAIL prio_ch1_rdata got=%h want=%h", rdata, 16'h0111 ^ 16'h5A5A); end
        req[1] = 1'b0;
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 22'h000AA) begin failures++; $display("FAIL prio_ch0_issue valid=%b addr=%h want valid=1 addr=000aa", cmd_valid, cmd_addr); end
        wait_ack(40, a);
        checks++; if (a !== 3'b001) begin failures++; $display("FAIL prio_second_ack got=%b want=001", a); end
        checks++; if (rdata !== (16'h00AA ^ 16'h5A5A)) begin failures++; $display("FAIL prio_ch0_rdata got=%h want=%h", rdata, 16'h00AA ^ 16'h5A5A); end
        req = 3'b000;
    endtask

    task automatic test_ch0_over_ch2();
        logic [2:0] a;
        do_reset();
        addr0 = 22'h00010; addr2 = 22'h00020; we = 3'b000;
        req = 3'b101;
        wait_ack(40, a);
        checks++; if (a !== 3'b001) begin failures++; $display("FAIL ch0_before_ch2 got=%b want=001", a); end
        req[0] = 1'b0;
        wait_ack(40, a);
        checks++; if (a !== 3'b100) begin failures++; $display("FAIL ch2_after_ch0 got=%b want=100", a); end
        checks++; if (rdata !== (16'h0020 ^ 16'h5A5A)) begin failures++; $display("FAIL ch2_rdata got=%h want=%h", rdata, 16'h0020 ^ 16'h5A5A); end
        req = 3'b000;
    endtask

    task automatic test_write_latch();
        logic [2:0] a;
        int         n;
        do_reset();
        ready_dly = 3;
        we = 3'b001; addr0 = 22'h12345; wdata0 = 16'hBEEF; wmask0 = 2'b01;
        req = 3'b001;
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL wr_issue_latency got=%b want=1", cmd_valid); end
        addr0 = 22'h3FFFF; wdata0 = 16'h1234; wmask0 = 2'b10; we = 3'b000;
        n = 0;
        while (cmd_valid && n < 10) begin
            checks++;
            if (cmd_addr !== 22'h12345 || cmd_wdata !== 16'hBEEF || cmd_mask !== 2'b01 || cmd_we !== 1'b1) begin
                failures++;
                $display("FAIL wr_fields addr=%h wdata=%h mask=%b we=%b want 12345 beef 01 1", cmd_addr, cmd_wdata, cmd_mask, cmd_we);
            end
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL wr_issue_cycles got=%0d want=4", n); end
        wait_ack(40, a);
        checks++; if (a !== 3'b001) begin failures++; $display("FAIL wr_ack got=%b want=001", a); end
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL wr_rdata got=%h want=0000", rdata); end
        req = 3'b000;
        repeat (12) @(negedge clk);
        checks++; if (ack_cnt0 !== 1) begin failures++; $display("FAIL wr_ack_count got=%0d want=1", ack_cnt0); end
    endtask

    task automatic test_urgent_refresh();
        int n;
        do_reset();
        n = 0;
        while (!cmd_valid && n < 900) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 781) begin failures++; $display("FAIL urg_ref_time got=%0d want=781", n); end
        checks++; if (cmd_refresh !== 1'b1) begin failures++; $display("FAIL urg_ref_flag got=%b want=1", cmd_refresh); end
        n = 0;
        while (cmd_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++; if (dut.ref_cnt_q !== 10'd0) begin failures++; $display("FAIL urg_ref_cnt_clear got=%0d want=0", dut.ref_cnt_q); end
        repeat (20) @(negedge clk);
        checks++; if (ref_acc !== 1) begin failures++; $display("FAIL urg_ref_count got=%0d want=1", ref_acc); end
        checks++; if (ack_cnt0 + ack_cnt1 + ack_cnt2 !== 0) begin failures++; $display("FAIL urg_ref_no_ack got=%0d want=0", ack_cnt0 + ack_cnt1 + ack_cnt2); end
    endtask

    task automatic test_opportunistic();
        logic saw;
        do_reset();
        repeat (400) @(negedge clk);
        refresh_hint = 1'b1;
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b1 || cmd_refresh !== 1'b1) begin failures++; $display("FAIL opp_ref_400 valid=%b refresh=%b want 1 1", cmd_valid, cmd_refresh); end
        refresh_hint = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (ref_acc !== 1) begin failures++; $display("FAIL opp_ref_count got=%0d want=1", ref_acc); end
        checks++; if (ack_cnt0 + ack_cnt1 + ack_cnt2 !== 0) begin failures++; $display("FAIL opp_ref_no_ack got=%0d want=0", ack_cnt0 + ack_cnt1 + ack_cnt2); end

        do_reset();
        repeat (200) @(negedge clk);
        refresh_hint = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_valid) saw = 1'b1;
        end
        refresh_hint = 1'b0;
        checks++; if (saw !== 1'b0) begin failures++; $display("FAIL opp_ref_200 issued=%b want=0", saw); end
    endtask

    task automatic test_starvation();
        logic [2:0] a;
        int         n12;
        logic       got2;
        do_reset();
        we = 3'b000; addr0 = 22'h000A0; addr1 = 22'h00B11; addr2 = 22'h00C22;
        req = 3'b111;
        n12 = 0; got2 = 1'b0;
        for (int k = 0; k < 20 && !got2; k++) begin
            wait_ack(60, a);
            if (a == 3'b100) begin
                got2 = 1'b1;
                checks++; if (rdata !== (16'h0C22 ^ 16'h5A5A)) begin failures++; $display("FAIL starve_ch2_rdata got=%h want=%h", rdata, 16'h0C22 ^ 16'h5A5A); end
                checks++; if (dut.starve_cnt_q !== 4'd0) begin failures++; $display("FAIL starve_cnt_clear got=%0d want=0", dut.starve_cnt_q); end
                req = 3'b000;
            end else if (a == 3'b000) begin
                k = 20;
            end else begin
                n12++;
            end
        end
        req = 3'b000;
        checks++; if (got2 !== 1'b1) begin failures++; $display("FAIL starve_ch2_granted got=%b want=1", got2); end
        checks++; if (n12 !== 8) begin failures++; $display("FAIL starve_grants_before_ch2 got=%0d want=8", n12); end
        repeat (12) @(negedge clk);
        checks++; if (ack_cnt1 !== 8 || ack_cnt0 !== 0) begin failures++; $display("FAIL starve_ack_counts ch1=%0d ch0=%0d want 8 0", ack_cnt1, ack_cnt0); end
        checks++; if (multi_ack !== 0) begin failures++; $display("FAIL multi_ack got=%0d want=0", multi_ack); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] a;
        do_reset();
        eng_en = 1'b0;
        we = 3'b000; addr0 = 22'h00333;
        req = 3'b001;
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL rstmid_issue got=%b want=1", cmd_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL rstmid_cmd_valid got=%b want=0", cmd_valid); end
        checks++; if (ack !== 3'b000) begin failures++; $display("FAIL rstmid_ack got=%b want=000", ack); end
        @(negedge clk);
        reset = 1'b0;
        eng_en = 1'b1;
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 22'h00333) begin failures++; $display("FAIL rstmid_reissue valid=%b addr=%h want 1 00333", cmd_valid, cmd_addr); end
        wait_ack(40, a);
        checks++; if (a !== 3'b001) begin failures++; $display("FAIL rstmid_ack_after got=%b want=001", a); end
        req = 3'b000;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_ch0_over_ch2();
        test_write_latch();
        test_urgent_refresh();
        test_opportunistic();
        test_starvation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
